// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the matrix keypad scanner.
// FSM states, frame results and code-width helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } kp_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_ONE,
    FR_MULTI
  } frame_res_t;

  function automatic int code_w(
    input int rows,
    input int cols
  );
    return (rows * cols > 1) ?
      $clog2(rows * cols) : 1;
  endfunction

endpackage

// File: rtl/matrix_keypad_scan_if.sv
// matrix_keypad_scan_if: keypad pins and key event outputs.
// master is the scanner, slave is the keypad/consumer side.
interface matrix_keypad_scan_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CODE_W = keypad_pkg::code_w(ROWS, COLS)
);

  logic [ROWS-1:0]   row_n;
  logic [COLS-1:0]   col_n;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_down;
  logic              multi_key;

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_down,
    output multi_key
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_down,
    input  multi_key
  );

endinterface

// File: rtl/keypad_frame_scan.sv
// keypad_frame_scan: row sync, slot timing, column drive and
// per-frame press accumulation.
module keypad_frame_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int CODE_W   = code_w(ROWS, COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic              frame_done,
  output frame_res_t        frame_res,
  output logic [CODE_W-1:0] frame_code
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(COLS);

  logic [ROWS-1:0]   sync1;
  logic [ROWS-1:0]   sync2;
  logic [SW-1:0]     slot;
  logic [CW-1:0]     col;
  logic [COLS-1:0]   col_q;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] acc_code;
  logic [1:0]        col_cnt;
  logic [CODE_W-1:0] col_code;
  logic [2:0]        sum;
  logic [1:0]        tot_cnt;
  logic [CODE_W-1:0] tot_code;
  logic              slot_last;
  logic              col_last;

  assign slot_last = slot == SW'(SCAN_DIV - 1);
  assign col_last  = col == CW'(COLS - 1);
  assign col_n     = col_q;

  // Walk rows downward so the lowest pressed row wins the code.
  always_comb begin
    col_cnt  = '0;
    col_code = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!sync2[r]) begin
        col_code = CODE_W'(r * COLS + int'(col));
        if (col_cnt != 2'd2)
          col_cnt = col_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    sum      = {1'b0, acc_cnt} + {1'b0, col_cnt};
    tot_cnt  = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    tot_code = (acc_cnt != 2'd0) ? acc_code : col_code;
  end

  always_comb begin
    frame_done = slot_last && col_last;
    frame_code = tot_code;
    frame_res  = FR_NONE;
    unique case (1'b1)
      tot_cnt == 2'd0: frame_res = FR_NONE;
      tot_cnt == 2'd1: frame_res = FR_ONE;
      tot_cnt[1]:      frame_res = FR_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= '1;
      sync2    <= '1;
      slot     <= '0;
      col      <= '0;
      col_q    <= ~COLS'(1);
      acc_cnt  <= '0;
      acc_code <= '0;
    end else begin
      sync1 <= row_n;
      sync2 <= sync1;
      if (slot_last) begin
        slot  <= '0;
        col   <= col_last ? '0 : col + CW'(1);
        col_q <= {col_q[COLS-2:0], col_q[COLS-1]};
        if (col_last) begin
          acc_cnt  <= '0;
          acc_code <= '0;
        end else begin
          acc_cnt  <= tot_cnt;
          acc_code <= tot_code;
        end
      end else begin
        slot <= slot + SW'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_keypad_scan.sv
// matrix_keypad_scan: debounced matrix keypad scanner with
// press strobe, held-key level and multi-key flag.
module matrix_keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 3,
  parameter int CODE_W   = code_w(ROWS, COLS)
) (
  input logic                 clk,
  input logic                 rst,
  matrix_keypad_scan_if.master kp
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic              frame_done;
  frame_res_t        frame_res;
  logic [CODE_W-1:0] frame_code;

  kp_state_t         state;
  kp_state_t         state_d;
  logic [DW-1:0]     cnt;
  logic [DW-1:0]     cnt_d;
  logic [DW-1:0]     cnt_inc;
  logic              cnt_hit;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_d;
  logic              accept;
  logic              release_k;

  logic [CODE_W-1:0] key_code;
  logic [CODE_W-1:0] key_code_d;
  logic              key_valid;
  logic              key_valid_d;
  logic              key_down;
  logic              key_down_d;
  logic              multi_key;
  logic              multi_key_d;

  keypad_frame_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .CODE_W   (CODE_W)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row_n      (kp.row_n),
    .col_n      (kp.col_n),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code)
  );

  assign kp.key_code  = key_code;
  assign kp.key_valid = key_valid;
  assign kp.key_down  = key_down;
  assign kp.multi_key = multi_key;

  // Saturating increment and "enough identical frames" test.
  always_comb begin
    cnt_inc = (int'(cnt) >= DEBOUNCE) ? cnt : cnt + DW'(1);
    cnt_hit = int'(cnt_inc) >= DEBOUNCE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cand  <= cand_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    cand_d    = cand;
    accept    = 1'b0;
    release_k = 1'b0;
    if (frame_done) begin
      unique case (state)
        S_IDLE: begin
          cnt_d = '0;
          if (frame_res == FR_ONE) begin
            cand_d = frame_code;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end else begin
              cnt_d   = DW'(1);
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (frame_res == FR_ONE && frame_code == cand) begin
            if (cnt_hit) begin
              accept  = 1'b1;
              cnt_d   = '0;
              state_d = S_PRESSED;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          cnt_d = '0;
          if (frame_res == FR_NONE) begin
            if (DEBOUNCE == 1) begin
              release_k = 1'b1;
              state_d   = S_IDLE;
            end else begin
              cnt_d   = DW'(1);
              state_d = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (frame_res == FR_NONE) begin
            if (cnt_hit) begin
              release_k = 1'b1;
              cnt_d     = '0;
              state_d   = S_IDLE;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d   = '0;
            state_d = S_PRESSED;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code;
    key_down_d  = key_down;
    if (accept)
      key_down_d = 1'b1;
    else if (release_k)
      key_down_d = 1'b0;
    multi_key_d = frame_done ?
      (frame_res == FR_MULTI) : multi_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      multi_key <= 1'b0;
    end else begin
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      key_down  <= key_down_d;
      multi_key <= multi_key_d;
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scan.sv
// tb_matrix_keypad_scan: frame-level vectors against a keypad
// model, plus reset and mid-press reset sequences.
module tb_matrix_keypad_scan;
  import keypad_pkg::*;

  localparam int ROWS     = 4;
  localparam int COLS     = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = COLS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  row_drv;

  int errors  = 0;
  int checks  = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  matrix_keypad_scan_if #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) kp ();

  // Keypad model: a held key pulls its row low while its
  // column is driven low.
  always_comb begin
    row_drv = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !kp.col_n[c])
          row_drv[r] = 1'b0;
  end
  assign kp.row_n = row_drv;

  matrix_keypad_scan #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always @(negedge clk)
    if (kp.key_valid === 1'b1)
      strobes++;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " col_n"}, kp.col_n, 4'b1110);
    chk({tag, " key_code"}, kp.key_code, 0);
    chk({tag, " key_valid"}, kp.key_valid, 0);
    chk({tag, " key_down"}, kp.key_down, 0);
    chk({tag, " multi_key"}, kp.multi_key, 0);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic        v;
    logic        d;
    logic        m;
    logic [3:0]  c;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic [15:0] k,
    input logic        v,
    input logic        d,
    input logic        m,
    input logic [3:0]  c
  );
    vec_t e;
    e.keys = k;
    e.v    = v;
    e.d    = d;
    e.m    = m;
    e.c    = c;
    tbl.push_back(e);
  endtask

  localparam logic [15:0] K0  = 16'h0001;
  localparam logic [15:0] K5  = 16'h0020;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;

  int n;
  int s0;
  logic [3:0] exp_col [5];

  initial begin
    // clean press of key 6, held 6 frames
    add(K6, 0, 0, 0, 0);
    add(K6, 0, 0, 0, 0);
    add(K6, 1, 1, 0, 6);
    add(K6, 0, 1, 0, 6);
    add(K6, 0, 1, 0, 6);
    add(K6, 0, 1, 0, 6);
    add(0,  0, 1, 0, 6);
    add(0,  0, 1, 0, 6);
    add(0,  0, 0, 0, 6);
    // bounce on key 9
    add(K9, 0, 0, 0, 6);
    add(K9, 0, 0, 0, 6);
    add(0,  0, 0, 0, 6);
    add(K9, 0, 0, 0, 6);
    add(K9, 0, 0, 0, 6);
    add(K9, 1, 1, 0, 9);
    add(0,  0, 1, 0, 9);
    add(0,  0, 1, 0, 9);
    add(0,  0, 0, 0, 9);
    // keys 0 and 5 together, then 0 alone
    add(K0 | K5, 0, 0, 1, 9);
    add(K0 | K5, 0, 0, 1, 9);
    add(K0, 0, 0, 0, 9);
    add(K0, 0, 0, 0, 9);
    add(K0, 1, 1, 0, 0);
    // release glitch and second key while pressed
    add(0,  0, 1, 0, 0);
    add(K0, 0, 1, 0, 0);
    add(K0, 0, 1, 0, 0);
    add(K0 | K5, 0, 1, 1, 0);
    add(K0, 0, 1, 0, 0);
    add(0,  0, 1, 0, 0);
    add(0,  0, 1, 0, 0);
    add(0,  0, 0, 0, 0);
    // different key mid-debounce restarts
    add(K6, 0, 0, 0, 0);
    add(K9, 0, 0, 0, 0);
    add(K9, 0, 0, 0, 0);
    add(K9, 0, 0, 0, 0);
    add(K9, 1, 1, 0, 9);
    add(0,  0, 1, 0, 9);
    add(0,  0, 1, 0, 9);
    add(0,  0, 0, 0, 9);

    exp_col[0] = 4'b1110;
    exp_col[1] = 4'b1101;
    exp_col[2] = 4'b1011;
    exp_col[3] = 4'b0111;
    exp_col[4] = 4'b1110;

    repeat (3) @(negedge clk);
    chk_reset("in reset");
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      chk($sformatf("col_n step%0d", i),
          kp.col_n, exp_col[i]);
      if (i < 4)
        repeat (SCAN_DIV) @(negedge clk);
    end
    chk_reset("after reset");

    for (int i = 0; i < tbl.size(); i++) begin
      keys = tbl[i].keys;
      repeat (FRAME) @(negedge clk);
      chk($sformatf("vec%0d key_valid", i),
          kp.key_valid, tbl[i].v);
      chk($sformatf("vec%0d key_down", i),
          kp.key_down, tbl[i].d);
      chk($sformatf("vec%0d multi_key", i),
          kp.multi_key, tbl[i].m);
      chk($sformatf("vec%0d key_code", i),
          kp.key_code, tbl[i].c);
    end
    chk("table strobes", strobes, 4);

    // key 15 accepted, then reset while held
    keys = K15;
    repeat (3 * FRAME) @(negedge clk);
    chk("k15 valid", kp.key_valid, 1);
    chk("k15 code", kp.key_code, 15);
    @(negedge clk);
    chk("k15 valid width", kp.key_valid, 0);
    repeat (FRAME + 5) @(negedge clk);
    chk("k15 held", kp.key_down, 1);
    rst = 1'b0;
    #1;
    chk_reset("mid-press reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    s0 = strobes;
    n  = 0;
    for (int i = 1; i <= 5 * FRAME; i++) begin
      @(negedge clk);
      if (kp.key_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("re-detect seen", (n != 0), 1);
    chk("re-detect window",
        (n >= 3 * FRAME) && (n <= 4 * FRAME + 3), 1);
    chk("re-detect code", kp.key_code, 15);
    @(negedge clk);
    chk("re-detect width", kp.key_valid, 0);
    chk("re-detect strobes", strobes - s0, 1);
    chk("total strobes", strobes, 6);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
